mem_copy_dma: RTL and testbench

MEM_COPY_DMA -- requirements
Module: mem_copy_dma

---
 rtl/mem_copy_dma.sv | 136 +++++++++++++
 tb/tb_mem_copy_dma.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: single-channel word copy engine. Each word is moved with one
// read cycle into an internal buffer followed by one write cycle, in
// ascending address order, with abort and a one-cycle completion pulse.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CHIP_ENABLE
`define CHIP_ENABLE 1'b1
`endif
`ifndef WRITE_ENABLE
`define WRITE_ENABLE 1'b1
`endif

module mem_copy_dma #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [`ADDR_WIDTH-1:0] src_addr_i,
    input  logic [`ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]   len_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LEN_WIDTH-1:0]   remain_o,
    output logic                   mem_ce_o,
    output logic                   mem_we_o,
    output logic [`ADDR_WIDTH-1:0] mem_addr_o,
    output logic [`DATA_WIDTH-1:0] mem_data_o,
    input  logic [`DATA_WIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clears the two low address bits so every access is word aligned.
    localparam logic [`ADDR_WIDTH-1:0] WORD_MASK = ~(`ADDR_WIDTH'(3));
    localparam logic [`ADDR_WIDTH-1:0] WORD_STEP = `ADDR_WIDTH'(4);

    state_t                   state;
    state_t                   state_nxt;
    logic [`ADDR_WIDTH-1:0]   src;
    logic [`ADDR_WIDTH-1:0]   dst;
    logic [LEN_WIDTH-1:0]     remain;
    logic [`DATA_WIDTH-1:0]   word_buf;

    // State register; reset drops straight to IDLE so no done pulse follows.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode: zero-length starts skip memory, abort ends in DONE.
    // NOTE: state_nxt gets a default before the case so no path can hold the
    // old value and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start_i) state_nxt = (len_i != '0) ? READ : DONE;
            READ:  state_nxt = abort_i ? DONE : WRITE;
            WRITE: state_nxt = (abort_i || remain <= LEN_WIDTH'(1)) ? DONE : READ;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the request in IDLE, capture read data in READ, and
    // step pointers / count in WRITE (the write itself always completes).
    // NOTE: the word buffer is a single register, not a memory array, so it
    // is cleared on reset along with the address registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            src      <= '0;
            dst      <= '0;
            remain   <= '0;
            word_buf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        src    <= src_addr_i & WORD_MASK;
                        dst    <= dst_addr_i & WORD_MASK;
                        remain <= len_i;
                    end
                end
                READ: word_buf <= mem_data_i;
                WRITE: begin
                    src    <= src + WORD_STEP;
                    dst    <= dst + WORD_STEP;
                    remain <= remain - LEN_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Output decode: memory bus idles at zero outside READ and WRITE.
    always_comb begin
        busy_o     = 1'b0;
        done_o     = 1'b0;
        mem_ce_o   = ~`CHIP_ENABLE;
        mem_we_o   = ~`WRITE_ENABLE;
        mem_addr_o = '0;
        mem_data_o = '0;
        case (state)
            READ: begin
                busy_o     = 1'b1;
                mem_ce_o   = `CHIP_ENABLE;
                mem_addr_o = src;
            end
            WRITE: begin
                busy_o     = 1'b1;
                mem_ce_o   = `CHIP_ENABLE;
                mem_we_o   = `WRITE_ENABLE;
                mem_addr_o = dst;
                mem_data_o = word_buf;
            end
            DONE: done_o = 1'b1;
            default: ;
        endcase
    end

    assign remain_o = remain;

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: memory model plus scoreboard of expected reads and
// writes; each scenario task checks cycle-exact handshake behaviour.

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mem_copy_dma;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o;
    logic        done_o;
    logic [15:0] remain_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i = '0;

    logic [31:0] mem [logic [31:0]];
    wr_t         exp_wr_q[$];
    logic [31:0] exp_rd_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    mem_copy_dma #(.LEN_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .busy_o(busy_o), .done_o(done_o), .remain_o(remain_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory model and scoreboard: outputs are stable mid-cycle, so accesses
    // are observed on the falling edge; read data is presented before the
    // capturing rising edge.
    always @(negedge clk_i) begin
        mem_data_i = '0;
        if (mem_ce_o && !mem_we_o) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
                $display("FAIL rd_unexpected: read at %h, none expected", mem_addr_o);
            end else begin
                logic [31:0] ea;
                ea = exp_rd_q.pop_front();
                if (mem_addr_o !== ea)
                    $display("FAIL rd_addr: got %h expected %h", mem_addr_o, ea);
                else n_pass++;
            end
            mem_data_i = mem_rd(mem_addr_o);
        end else if (mem_ce_o && mem_we_o) begin
            n_checks++;
            if (exp_wr_q.size() == 0) begin
                $display("FAIL wr_unexpected: write %h at %h, none expected", mem_data_o, mem_addr_o);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                if (mem_addr_o !== e.addr || mem_data_o !== e.data)
                    $display("FAIL wr: got %h@%h expected %h@%h", mem_data_o, mem_addr_o, e.data, e.addr);
                else n_pass++;
            end
            mem[mem_addr_o] = mem_data_o;
        end
    end

    // Reference model: word-by-word ascending copy of nw words, seeing its
    // own earlier writes so overlapping regions resolve as the order dictates.
    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int nw);
        logic [31:0] shadow [logic [31:0]];
        logic [31:0] sa, da, w;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        for (int i = 0; i < nw; i++) begin
            w = shadow.exists(sa) ? shadow[sa] : mem_rd(sa);
            exp_rd_q.push_back(sa);
            exp_wr_q.push_back('{addr: da, data: w});
            shadow[da] = w;
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(negedge clk_i);
        src_addr_i = s;
        dst_addr_i = d;
        len_i      = n;
        start_i    = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        #3;
        n_checks++;
        if ({busy_o, done_o, mem_ce_o, mem_we_o} !== 4'b0000 || remain_o !== 16'd0 ||
            mem_addr_o !== 32'd0 || mem_data_o !== 32'd0)
            $display("FAIL reset_outputs: busy=%b done=%b ce=%b we=%b remain=%h addr=%h data=%h",
                     busy_o, done_o, mem_ce_o, mem_we_o, remain_o, mem_addr_o, mem_data_o);
        else n_pass++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    // 4-word copy; abort raised together with start must not block it.
    task automatic test_copy4();
        for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4*i)] = 32'h1111_1111 * 32'(i + 1);
        push_copy(32'h100, 32'h200, 4);
        abort_i = 1'b1;
        issue(32'h100, 32'h200, 16'd4);
        abort_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (busy_o !== (c <= 8) || done_o !== (c == 9))
                $display("FAIL copy4_timing: cycle %0d busy=%b done=%b expected busy=%b done=%b",
                         c, busy_o, done_o, (c <= 8), (c == 9));
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem_rd(32'h200 + 32'(4*i)) !== 32'h1111_1111 * 32'(i + 1))
                $display("FAIL copy4_mem: word %0d got %h expected %h", i,
                         mem_rd(32'h200 + 32'(4*i)), 32'h1111_1111 * 32'(i + 1));
            else n_pass++;
        end
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || remain_o !== 16'd0)
            $display("FAIL copy4_drain: wr_left=%0d rd_left=%0d remain=%0d expected 0/0/0",
                     exp_wr_q.size(), exp_rd_q.size(), remain_o);
        else n_pass++;
    endtask

    task automatic test_len_zero();
        int ce_seen;
        ce_seen = 0;
        issue(32'h100, 32'h300, 16'd0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            if (mem_ce_o) ce_seen++;
            n_checks++;
            if (done_o !== (c == 1) || busy_o !== 1'b0)
                $display("FAIL len0_timing: cycle %0d done=%b busy=%b expected done=%b busy=0",
                         c, done_o, busy_o, (c == 1));
            else n_pass++;
        end
        n_checks++;
        if (ce_seen != 0) $display("FAIL len0_ce: ce asserted %0d cycles expected 0", ce_seen);
        else n_pass++;
    endtask

    task automatic test_wrap();
        mem[32'h100] = 32'hCAFE_0001;
        mem[32'h104] = 32'hCAFE_0002;
        push_copy(32'h103, 32'hFFFF_FFFC, 2);
        issue(32'h103, 32'hFFFF_FFFC, 16'd2);
        repeat (6) @(negedge clk_i);
        n_checks++;
        if (mem_rd(32'hFFFF_FFFC) !== 32'hCAFE_0001 || mem_rd(32'h0) !== 32'hCAFE_0002)
            $display("FAIL wrap_mem: got %h,%h expected cafe0001,cafe0002",
                     mem_rd(32'hFFFF_FFFC), mem_rd(32'h0));
        else n_pass++;
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0)
            $display("FAIL wrap_drain: wr_left=%0d rd_left=%0d expected 0", exp_wr_q.size(), exp_rd_q.size());
        else n_pass++;
    endtask

    // 8-word copy aborted during its 3rd WRITE (cycle 6).
    task automatic test_abort();
        int dones;
        dones = 0;
        push_copy(32'h300, 32'h400, 3);
        issue(32'h300, 32'h400, 16'd8);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            if (done_o) dones++;
            if (c == 6) abort_i = 1'b1;
            if (c == 7) begin
                abort_i = 1'b0;
                n_checks++;
                if (done_o !== 1'b1 || remain_o !== 16'd5)
                    $display("FAIL abort_end: done=%b remain=%0d expected 1/5", done_o, remain_o);
                else n_pass++;
            end
        end
        n_checks++;
        if (dones != 1 || busy_o !== 1'b0)
            $display("FAIL abort_pulse: done pulses %0d busy=%b expected 1/0", dones, busy_o);
        else n_pass++;
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || mem.exists(32'h40C))
            $display("FAIL abort_writes: wr_left=%0d rd_left=%0d 4th_written=%b expected 0/0/0",
                     exp_wr_q.size(), exp_rd_q.size(), mem.exists(32'h40C));
        else n_pass++;
    endtask

    // start held high from busy through DONE with a different request.
    task automatic test_start_ignored();
        push_copy(32'h500, 32'h600, 3);
        issue(32'h500, 32'h600, 16'd3);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk_i);
            if (c == 2) begin
                src_addr_i = 32'h700;
                dst_addr_i = 32'h800;
                len_i      = 16'd1;
                start_i    = 1'b1;
            end
            if (c == 8) start_i = 1'b0;
            if (c >= 7) begin
                n_checks++;
                if (done_o !== (c == 7) || busy_o !== 1'b0)
                    $display("FAIL ignore_start: cycle %0d done=%b busy=%b expected done=%b busy=0",
                             c, done_o, busy_o, (c == 7));
                else n_pass++;
            end
        end
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0 || mem.exists(32'h800))
            $display("FAIL ignore_drain: wr_left=%0d rd_left=%0d 0x800_written=%b expected 0/0/0",
                     exp_wr_q.size(), exp_rd_q.size(), mem.exists(32'h800));
        else n_pass++;
    endtask

    // Overlapping dst = src + 4: first word propagates through the region.
    task automatic test_overlap();
        mem[32'hC00] = 32'hAAAA_0000;
        mem[32'hC04] = 32'hBBBB_0000;
        mem[32'hC08] = 32'hCCCC_0000;
        push_copy(32'hC00, 32'hC04, 3);
        issue(32'hC00, 32'hC04, 16'd3);
        repeat (9) @(negedge clk_i);
        n_checks++;
        if (mem_rd(32'hC0C) !== 32'hAAAA_0000 || exp_wr_q.size() != 0)
            $display("FAIL overlap: last word %h wr_left=%0d expected aaaa0000/0", mem_rd(32'hC0C), exp_wr_q.size());
        else n_pass++;
    endtask

    // Reset pulse inside the 3rd READ of a 6-word copy, then a fresh copy.
    task automatic test_reset_mid();
        int dones;
        dones = 0;
        push_copy(32'h900, 32'hA00, 2);
        issue(32'h900, 32'hA00, 16'd6);
        repeat (4) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, mem_ce_o, mem_we_o} !== 4'b0000 || remain_o !== 16'd0 || mem_addr_o !== 32'd0)
            $display("FAIL midreset_clear: busy=%b done=%b ce=%b we=%b remain=%0d addr=%h expected all 0",
                     busy_o, done_o, mem_ce_o, mem_we_o, remain_o, mem_addr_o);
        else n_pass++;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            if (done_o || busy_o) dones++;
        end
        n_checks++;
        if (dones != 0 || exp_wr_q.size() != 0 || mem_rd(32'hA04) !== mem_rd(32'h904) || mem.exists(32'hA08))
            $display("FAIL midreset_state: activity=%0d wr_left=%0d a08_written=%b expected 0/0/0",
                     dones, exp_wr_q.size(), mem.exists(32'hA08));
        else n_pass++;
        push_copy(32'h900, 32'hB00, 1);
        issue(32'h900, 32'hB00, 16'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            n_checks++;
            if (done_o !== (c == 3) || busy_o !== (c <= 2))
                $display("FAIL midreset_restart: cycle %0d done=%b busy=%b expected done=%b busy=%b",
                         c, done_o, busy_o, (c == 3), (c <= 2));
            else n_pass++;
        end
        n_checks++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0)
            $display("FAIL midreset_drain: wr_left=%0d rd_left=%0d expected 0", exp_wr_q.size(), exp_rd_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_copy4();
        test_len_zero();
        test_wrap();
        test_abort();
        test_start_ignored();
        test_overlap();
        test_reset_mid();
        repeat (2) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
